// File: rtl/writeback_stage_if.sv
// Bundle between memory stage / register file / top and the W stage.
// slave: stage side; master: driver of m_* and observer of W outputs.
interface writeback_stage_if #(
   parameter int XLEN  = 64,
   parameter int CNT_W = 32
);
   logic             m_valid;
   logic [2:0]       m_stat;
   logic [3:0]       m_icode;
   logic [3:0]       m_dste;
   logic [3:0]       m_dstm;
   logic [XLEN-1:0]  m_vale;
   logic [XLEN-1:0]  m_valm;
   logic             w_stall;
   logic             w_bubble;
   logic             w_valid;
   logic [2:0]       w_stat;
   logic [3:0]       w_icode;
   logic             we_e;
   logic [3:0]       waddr_e;
   logic [XLEN-1:0]  wdata_e;
   logic             we_m;
   logic [3:0]       waddr_m;
   logic [XLEN-1:0]  wdata_m;
   logic [2:0]       proc_stat;
   logic             halted;
   logic [CNT_W-1:0] retired;

   modport master (
      output m_valid, m_stat, m_icode, m_dste, m_dstm,
      output m_vale, m_valm, w_stall, w_bubble,
      input  w_valid, w_stat, w_icode,
      input  we_e, waddr_e, wdata_e,
      input  we_m, waddr_m, wdata_m,
      input  proc_stat, halted, retired
   );

   modport slave (
      input  m_valid, m_stat, m_icode, m_dste, m_dstm,
      input  m_vale, m_valm, w_stall, w_bubble,
      output w_valid, w_stat, w_icode,
      output we_e, waddr_e, wdata_e,
      output we_m, waddr_m, wdata_m,
      output proc_stat, halted, retired
   );
endinterface

// File: rtl/writeback_stage.sv
// Y86-64 W stage: W pipeline register, register-file write ports,
// processor status FSM and retired-instruction counter.
// Ports: clock, reset (async, active-high), wb (writeback_stage_if.slave).
module writeback_stage #(
   parameter int XLEN  = 64,
   parameter int CNT_W = 32
) (
   input logic             clock,
   input logic             reset,
   writeback_stage_if.slave wb
);

   localparam logic [3:0] RNONE = 4'hF;
   localparam logic [3:0] INOP  = 4'h1;
   localparam logic [2:0] SAOK  = 3'd1;
   localparam logic [2:0] SHLT  = 3'd2;
   localparam logic [2:0] SADR  = 3'd3;
   localparam logic [2:0] SINS  = 3'd4;

   typedef enum logic [1:0] {RUN, HALT, ERR} state_t;

   logic             valid_q;
   logic [2:0]       stat_q;
   logic [3:0]       icode_q;
   logic [3:0]       dste_q;
   logic [3:0]       dstm_q;
   logic [XLEN-1:0]  vale_q;
   logic [XLEN-1:0]  valm_q;

   state_t           state_q, state_d;
   logic [2:0]       pstat_q, pstat_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             run;
   logic             slot_ok;
   logic             we_m_int;
   logic             we_e_int;

   // W pipeline register; stall outranks bubble
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
         stat_q  <= SAOK;
         icode_q <= INOP;
         dste_q  <= RNONE;
         dstm_q  <= RNONE;
         vale_q  <= '0;
         valm_q  <= '0;
      end else if (!wb.w_stall) begin
         if (wb.w_bubble) begin
            valid_q <= 1'b0;
            stat_q  <= SAOK;
            icode_q <= INOP;
            dste_q  <= RNONE;
            dstm_q  <= RNONE;
            vale_q  <= '0;
            valm_q  <= '0;
         end else begin
            valid_q <= wb.m_valid;
            stat_q  <= wb.m_stat;
            icode_q <= wb.m_icode;
            dste_q  <= wb.m_dste;
            dstm_q  <= wb.m_dstm;
            vale_q  <= wb.m_vale;
            valm_q  <= wb.m_valm;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= RUN;
         pstat_q <= SAOK;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pstat_q <= pstat_d;
         cnt_q   <= cnt_d;
      end
   end

   assign run     = (state_q == RUN);
   assign slot_ok = valid_q && (stat_q == SAOK);

   // Faulting slot stops the machine; good slot retires when it
   // leaves W (not while stalled). HALT/ERR hold until reset.
   always_comb begin
      state_d = state_q;
      pstat_d = pstat_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         RUN: begin
            if (valid_q && (stat_q != SAOK)) begin
               if (stat_q == SHLT) begin
                  state_d = HALT;
                  pstat_d = SHLT;
               end else if (stat_q == SADR || stat_q == SINS) begin
                  state_d = ERR;
                  pstat_d = stat_q;
               end else begin
                  state_d = ERR;
                  pstat_d = SINS;
               end
            end else if (slot_ok && !wb.w_stall && (cnt_q != '1)) begin
               cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         default: begin
            state_d = state_q;
         end
      endcase
   end

   // Same destination on both ports: M wins (popq %rsp)
   assign we_m_int = slot_ok && (dstm_q != RNONE) && run;
   assign we_e_int = slot_ok && (dste_q != RNONE) && run &&
                     !((dste_q == dstm_q) && we_m_int);

   assign wb.w_valid   = valid_q;
   assign wb.w_stat    = stat_q;
   assign wb.w_icode   = icode_q;
   assign wb.we_e      = we_e_int;
   assign wb.waddr_e   = dste_q;
   assign wb.wdata_e   = vale_q;
   assign wb.we_m      = we_m_int;
   assign wb.waddr_m   = dstm_q;
   assign wb.wdata_m   = valm_q;
   assign wb.proc_stat = pstat_q;
   assign wb.halted    = (pstat_q != SAOK);
   assign wb.retired   = cnt_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: slot/status/count model,
// per-cycle compare, directed vectors with literal expectations.
module tb_writeback_stage;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   writeback_stage_if #(.XLEN(64), .CNT_W(32)) wb ();
   writeback_stage_if #(.XLEN(64), .CNT_W(4))  ws ();

   writeback_stage #(.XLEN(64), .CNT_W(32)) dut (
      .clock(clk), .reset(rst), .wb(wb.slave));

   // Narrow counter copy fed the same stream to exercise saturation
   writeback_stage #(.XLEN(64), .CNT_W(4)) dut_s (
      .clock(clk), .reset(rst), .wb(ws.slave));

   assign ws.m_valid  = wb.m_valid;
   assign ws.m_stat   = wb.m_stat;
   assign ws.m_icode  = wb.m_icode;
   assign ws.m_dste   = wb.m_dste;
   assign ws.m_dstm   = wb.m_dstm;
   assign ws.m_vale   = wb.m_vale;
   assign ws.m_valm   = wb.m_valm;
   assign ws.w_stall  = wb.w_stall;
   assign ws.w_bubble = wb.w_bubble;

   typedef struct {
      bit        valid;
      bit [2:0]  stat;
      bit [3:0]  icode;
      bit [3:0]  dste;
      bit [3:0]  dstm;
      bit [63:0] vale;
      bit [63:0] valm;
   } slot_t;

   localparam slot_t BUB = '{1'b0, 3'd1, 4'h1, 4'hF, 4'hF, 64'd0, 64'd0};

   slot_t slot = BUB;
   int    mstat = 1;
   int    cnt = 0;

   task automatic chk(string n, logic [63:0] a, logic [63:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s got %h expected %h", n, a, e);
      end
   endtask

   // Model: an instruction retires when it leaves W in a running
   // machine; a bad status in W stops the machine for good.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         slot  = BUB;
         mstat = 1;
         cnt   = 0;
      end else begin
         if (mstat == 1 && slot.valid) begin
            if (slot.stat == 1) begin
               if (!wb.w_stall) cnt = cnt + 1;
            end else begin
               mstat = (slot.stat >= 2 && slot.stat <= 4) ? int'(slot.stat) : 4;
            end
         end
         if (!wb.w_stall) begin
            if (wb.w_bubble) slot = BUB;
            else slot = '{wb.m_valid, wb.m_stat, wb.m_icode, wb.m_dste,
                          wb.m_dstm, wb.m_vale, wb.m_valm};
         end
      end
   end

   always @(negedge clk) begin
      bit good, ewm, ewe;
      good = slot.valid && slot.stat == 1 && mstat == 1;
      ewm  = good && slot.dstm != 4'hF;
      ewe  = good && slot.dste != 4'hF && !(slot.dste == slot.dstm && ewm);
      chk("w_valid",   64'(wb.w_valid),   64'(slot.valid));
      chk("w_stat",    64'(wb.w_stat),    64'(slot.stat));
      chk("w_icode",   64'(wb.w_icode),   64'(slot.icode));
      chk("we_e",      64'(wb.we_e),      64'(ewe));
      chk("waddr_e",   64'(wb.waddr_e),   64'(slot.dste));
      chk("wdata_e",   wb.wdata_e,        slot.vale);
      chk("we_m",      64'(wb.we_m),      64'(ewm));
      chk("waddr_m",   64'(wb.waddr_m),   64'(slot.dstm));
      chk("wdata_m",   wb.wdata_m,        slot.valm);
      chk("proc_stat", 64'(wb.proc_stat), 64'(mstat));
      chk("halted",    64'(wb.halted),    64'(mstat != 1));
      chk("retired",   64'(wb.retired),   64'(cnt));
      chk("retired_s", 64'(ws.retired),   64'(cnt > 15 ? 15 : cnt));
   end

   task automatic drive(bit v, bit [2:0] s, bit [3:0] ic, bit [3:0] de,
                        bit [3:0] dm, bit [63:0] ve, bit [63:0] vm,
                        bit st = 1'b0, bit bb = 1'b0);
      wb.m_valid  = v;
      wb.m_stat   = s;
      wb.m_icode  = ic;
      wb.m_dste   = de;
      wb.m_dstm   = dm;
      wb.m_vale   = ve;
      wb.m_valm   = vm;
      wb.w_stall  = st;
      wb.w_bubble = bb;
      @(negedge clk);
   endtask

   task automatic nop();
      drive(1'b0, 3'd1, 4'h1, 4'hF, 4'hF, 64'd0, 64'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      wb.m_valid = 0; wb.m_stat = 1; wb.m_icode = 1;
      wb.m_dste = 4'hF; wb.m_dstm = 4'hF;
      wb.m_vale = 0; wb.m_valm = 0;
      wb.w_stall = 0; wb.w_bubble = 0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_valid", 64'(wb.w_valid), 64'd0);
      chk("rst_icode", 64'(wb.w_icode), 64'd1);
      chk("rst_pstat", 64'(wb.proc_stat), 64'd1);
      chk("rst_ret",   64'(wb.retired), 64'd0);

      // irmovq $0x1234, %rdx
      drive(1, 1, 4'h3, 4'h2, 4'hF, 64'h1234, 64'd0);
      chk("irm_we_e",  64'(wb.we_e), 64'd1);
      chk("irm_addr",  64'(wb.waddr_e), 64'd2);
      chk("irm_data",  wb.wdata_e, 64'h1234);
      chk("irm_we_m",  64'(wb.we_m), 64'd0);
      chk("irm_ret0",  64'(wb.retired), 64'd0);
      nop();
      chk("irm_ret1",  64'(wb.retired), 64'd1);

      // popq %rsp
      drive(1, 1, 4'hB, 4'h4, 4'h4, 64'h108, 64'hABC);
      chk("pop_we_m",  64'(wb.we_m), 64'd1);
      chk("pop_data",  wb.wdata_m, 64'hABC);
      chk("pop_we_e",  64'(wb.we_e), 64'd0);
      nop();
      chk("pop_ret",   64'(wb.retired), 64'd2);

      // opq held by stall+bubble for 3 cycles
      drive(1, 1, 4'h6, 4'h3, 4'hF, 64'h55, 64'd0);
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 4'h2, 4'h7, 4'hF, 64'h99, 64'd0, 1'b1, 1'b1);
         chk("stl_icode", 64'(wb.w_icode), 64'd6);
         chk("stl_data",  wb.wdata_e, 64'h55);
         chk("stl_we_e",  64'(wb.we_e), 64'd1);
         chk("stl_ret",   64'(wb.retired), 64'd2);
      end
      drive(1, 1, 4'h2, 4'h7, 4'hF, 64'h99, 64'd0, 1'b0, 1'b1);
      chk("bub_ret",   64'(wb.retired), 64'd3);
      chk("bub_valid", 64'(wb.w_valid), 64'd0);
      chk("bub_we_e",  64'(wb.we_e), 64'd0);
      drive(1, 1, 4'h2, 4'h7, 4'hF, 64'h99, 64'd0, 1'b0, 1'b1);
      chk("bub_ret2",  64'(wb.retired), 64'd3);

      // asynchronous reset mid-run
      drive(1, 1, 4'h3, 4'h2, 4'hF, 64'h77, 64'd0);
      chk("mr_we_e0",  64'(wb.we_e), 64'd1);
      #2 rst = 1'b1;
      #1;
      chk("mr_we_e",   64'(wb.we_e), 64'd0);
      chk("mr_icode",  64'(wb.w_icode), 64'd1);
      chk("mr_ret",    64'(wb.retired), 64'd0);
      chk("mr_pstat",  64'(wb.proc_stat), 64'd1);
      nop();
      rst = 1'b0;

      // 20 retirements: wide counter reaches 20, 4-bit copy sticks at 15
      for (int i = 0; i < 20; i++)
         drive(1, 1, 4'h3, 4'h1, 4'hF, 64'(i), 64'd0);
      nop();
      chk("sat_wide",  64'(wb.retired), 64'd20);
      chk("sat_narrow", 64'(ws.retired), 64'd15);
      nop();
      chk("sat_hold",  64'(ws.retired), 64'd15);

      // AOK, HLT, AOK
      do_reset();
      drive(1, 1, 4'h3, 4'h5, 4'hF, 64'h1, 64'd0);
      drive(1, 2, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0);
      chk("hlt_pre",   64'(wb.proc_stat), 64'd1);
      drive(1, 1, 4'h3, 4'h6, 4'hF, 64'h2, 64'd0);
      chk("hlt_pstat", 64'(wb.proc_stat), 64'd2);
      chk("hlt_halt",  64'(wb.halted), 64'd1);
      chk("hlt_we_e",  64'(wb.we_e), 64'd0);
      chk("hlt_ret",   64'(wb.retired), 64'd1);
      nop();
      nop();
      chk("hlt_ret2",  64'(wb.retired), 64'd1);
      chk("hlt_stick", 64'(wb.proc_stat), 64'd2);

      // ADR fault
      do_reset();
      drive(1, 3, 4'h5, 4'hF, 4'h7, 64'd0, 64'h77);
      chk("adr_we_m",  64'(wb.we_m), 64'd0);
      chk("adr_pre",   64'(wb.proc_stat), 64'd1);
      drive(1, 1, 4'h3, 4'h2, 4'hF, 64'h5, 64'd0);
      chk("adr_pstat", 64'(wb.proc_stat), 64'd3);
      chk("adr_we_e",  64'(wb.we_e), 64'd0);
      nop();
      chk("adr_ret",   64'(wb.retired), 64'd0);
      chk("adr_stick", 64'(wb.proc_stat), 64'd3);
      do_reset();
      chk("adr_clr",   64'(wb.proc_stat), 64'd1);

      // invalid HLT slot ignored; unknown status maps to INS
      drive(0, 2, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0);
      nop();
      chk("inv_hlt",   64'(wb.proc_stat), 64'd1);
      drive(1, 5, 4'h0, 4'h3, 4'hF, 64'd0, 64'd0);
      nop();
      chk("odd_stat",  64'(wb.proc_stat), 64'd4);
      nop();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
W-stage pipeline register for the pipelined Y86-64 core; the write-side counterpart of the decode/register-read logic.
- Latches memory-stage results and drives the register file's two write ports (E and M).
- Owns the processor status state machine and a retired-instruction counter.
- Sits between the memory stage and the register file / top-level status outputs.

Parameters:
XLEN, 64, datapath width of valE/valM
CNT_W, 32, width of retired-instruction counter

Ports:
clock  input  1  system clock, rising edge active
reset  input  1  asynchronous, active-high reset
m_valid  input  1  memory-stage slot holds a real instruction (0 = bubble)
m_stat  input  3  memory-stage status: 1 AOK, 2 HLT, 3 ADR, 4 INS
m_icode  input  4  memory-stage icode
m_dste  input  4  destination for valE; 4'hF = none
m_dstm  input  4  destination for valM; 4'hF = none
m_vale  input  XLEN  ALU result
m_valm  input  XLEN  memory read result
w_stall  input  1  hold W register
w_bubble  input  1  load bubble into W register
w_valid  output  1  W slot valid
w_stat  output  3  latched status
w_icode  output  4  latched icode
we_e  output  1  register-file write enable, E port
waddr_e  output  4  E-port address (= W dstE)
wdata_e  output  XLEN  E-port data (= W valE)
we_m  output  1  register-file write enable, M port
waddr_m  output  4  M-port address (= W dstM)
wdata_m  output  XLEN  M-port data (= W valM)
proc_stat  output  3  processor status: 1 AOK, 2 HLT, 3 ADR, 4 INS
halted  output  1  processor stopped (proc_stat != AOK)
retired  output  CNT_W  count of instructions retired

Behaviour:
- Reset (asynchronous, immediate):
  - W register = bubble: w_valid 0, w_stat 1, w_icode 4'h1, dstE/dstM 4'hF, valE/valM 0.
  - proc_stat 1, halted 0, retired 0.
  - Applies mid-operation; any pending write is dropped.
- W register update on rising clock edge:
  - w_stall=1: hold all fields. Stall has priority over bubble when both are asserted.
  - w_bubble=1, stall=0: load bubble values as at reset.
  - Otherwise: load all m_* inputs. Latency is 1 cycle from M inputs to write-port outputs.
- Write ports (combinational from W register and FSM):
  - we_e = w_valid & (w_stat==1) & (dstE!=4'hF) & RUN & ~(dstE==dstM & we_m).
  - we_m = w_valid & (w_stat==1) & (dstM!=4'hF) & RUN.
  - When dstE==dstM, the M port wins and E is suppressed (popq %rsp semantics).
  - Address and data outputs always mirror the W fields, regardless of enables.
  - The register file commits on the following rising edge.
- Status FSM, states RUN / HALT / ERR:
  - RUN: proc_stat=1. On an edge where the W slot holds w_valid=1 and w_stat!=1:
    - w_stat=2 -> HALT, proc_stat=2.
    - w_stat=3 or 4 -> ERR, proc_stat=w_stat.
    - Any other value -> ERR, proc_stat=4.
  - The transition is evaluated on the W slot contents, so the faulting instruction never writes (enables already gated by w_stat).
  - HALT and ERR are sticky until reset. All enables stay 0 and W continues latching but is ignored.
  - halted = (proc_stat != 1).
- retired counter:
  - Increments by 1 on each edge where the W slot holds w_valid=1, w_stat=1, FSM in RUN, and w_stall=0.
  - A stalled slot counts once, on the edge it leaves W.
  - Saturates at all-ones; no wrap.
  - A halting instruction is not counted.
- Stalled slot: write enables remain asserted while stalled. Repeated writes of identical data are harmless.

Test Plan:
- Reset mid-run with valid irmovq in W -> we_e drops immediately, w_icode=1, retired=0, proc_stat=1.
- irmovq: m_valid=1, stat=1, dstE=2, valE=0x1234, dstM=F -> next cycle we_e=1, waddr_e=2, wdata_e=0x1234, we_m=0; retired 0->1 after following edge.
- popq %rsp: dstE=4, dstM=4, valE=0x108, valM=0xABC -> we_m=1 with wdata_m=0xABC, we_e=0.
- Sequence: valid AOK, then HLT, then valid AOK -> after HLT reaches W: proc_stat=2, halted=1, retired=1 and frozen, no further enables.
- w_stall and w_bubble both high for 3 cycles with valid opq in W -> W unchanged, retired incremented only once after stall releases. Bubble alone -> w_valid=0, no write, no count.
- Valid instruction with m_stat=3 -> no write, proc_stat=3 sticky until reset. Preload retired near saturation -> counter holds at 0xFFFFFFFF.
